dice_roll_collector: RTL
========================

DICE_ROLL_COLLECTOR -- requirements
Module: dice_roll_collector

Interface
REQ-001 Parameter DEPTH, default 4: FIFO entry count, power of two, minimum 2.
REQ-002 Parameter CNT_W, default 8: width of each per-face counter.
REQ-003 Port clk, input, 1: the single clock; all state updates on posedge clk.
REQ-004 Port rstn, input, 1: reset, synchronous and active-low.
REQ-005 Port in_valid, input, 1: a die roll is presented on in_roll (driven from the RNG's latched value).
REQ-006 Port in_roll, input, 3: roll value; legal values are 1..6.
REQ-007 Port in_ready, output, 1: collector can accept a roll this cycle.
REQ-008 Port out_valid, output, 1: FIFO head holds a roll.
REQ-009 Port out_roll, output, 3: FIFO head value.
REQ-010 Port out_ready, input, 1: downstream consumes the head this cycle.
REQ-011 Port clr, input, 1: clear statistics (counters, total, err).
REQ-012 Port face_sel, input, 3: face (1..6) whose count is reported.
REQ-013 Port face_cnt, output, CNT_W: registered count for face_sel.
REQ-014 Port total, output, 16: count of accepted legal rolls.
REQ-015 Port err, output, 1: sticky flag for an illegal roll value.

Function
REQ-016 Accept = in_valid & in_ready; in_ready = !full, combinational from the occupancy only; no pass-through when full, even if a pop occurs in the same cycle.
REQ-017 Legal accepted roll: push into the FIFO, increment that face counter, increment total.
REQ-018 Illegal accepted roll (0 or 7): no push, no counter or total change; err set next cycle.
REQ-019 Pop = out_valid & out_ready; out_valid = !empty.
REQ-020 out_roll = head value when out_valid; 3'd0 when empty.
REQ-021 Simultaneous push and pop with 0 < occupancy < DEPTH: occupancy unchanged; FIFO order preserved.
REQ-022 Push while empty: out_valid rises on the next cycle (1-cycle latency).
REQ-023 Pointers wrap modulo DEPTH; full and empty are distinguished with an extra pointer bit or an occupancy counter.
REQ-024 Face counters and total saturate at all-ones and never wrap.
REQ-025 face_cnt updates one cycle after face_sel; face_sel values of 0 or 7 report 0.
REQ-026 clr has priority over a same-cycle increment: the next cycle shows counters = 0, total = 0, err = 0, and the roll is still pushed if legal.
REQ-027 clr does not affect FIFO contents, pointers, in_ready or out_valid.
REQ-028 err stays set until clr or reset.

Reset
REQ-029 rstn low at a posedge: FIFO emptied, and out_valid = 0, out_roll = 0, in_ready = 1, face_cnt = 0, total = 0, err = 0 from the next cycle.
REQ-030 Reset mid-operation discards any in-flight push or pop in that cycle; the FIFO storage array needs no reset.

Structure
REQ-031 Shared package dice_pkg holds the face type (3-bit), FACE_MIN = 1, FACE_MAX = 6, and the legality check function.
REQ-032 The FIFO is a sub-module roll_fifo (parameter DEPTH, 3-bit data, valid/ready on both sides), instantiated once.
REQ-033 Statistics logic (six counters, total, err, face_cnt mux register) lives in the top module.

Verification
REQ-034 Reset, then push 3, 5, 1 with out_ready = 0 -> out_valid = 1, out_roll = 3; popping three times yields 3, 5, 1; total = 3.
REQ-035 With DEPTH = 4, push 5 rolls with out_ready = 0 -> in_ready = 0 after the 4th; the 5th is not accepted; total = 4.
REQ-036 Push 0, then push 7 -> err = 1, total unchanged, FIFO empty; clr -> err = 0.
REQ-037 Force the face-6 counter to 255 (CNT_W = 8), push 6 -> face_sel = 6 reports 255 (saturated), total incremented.
REQ-038 With occupancy 2, push 4 and pop in the same cycle -> occupancy stays 2; the new tail is 4.
REQ-039 clr with a same-cycle legal push of 2 -> face 2 count = 0 and total = 0 next cycle; out_roll eventually yields 2.

Source files
------------

// File: rtl/dice_pkg.sv
// Shared die-face type, legal face range and legality check for the roll collector.
package dice_pkg;

    typedef logic [2:0] face_t;

    localparam face_t FACE_MIN  = 3'd1;
    localparam face_t FACE_MAX  = 3'd6;
    localparam int    NUM_FACES = 6;

    function automatic logic is_legal(input face_t f);
        return (f >= FACE_MIN) && (f <= FACE_MAX);
    endfunction

endpackage

// File: rtl/roll_fifo.sv
// Small valid/ready FIFO of die faces; extra pointer bit separates full from empty.
module roll_fifo
    import dice_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rstn,
    input  logic  in_valid,
    input  face_t in_data,
    output logic  in_ready,
    output logic  out_valid,
    output face_t out_data,
    input  logic  out_ready
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    face_t       mem_q [DEPTH];
    logic        full, empty, push, pop;

    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is unreset; a push coinciding with reset is simply dropped.
    always_ff @(posedge clk) begin
        if (rstn && push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

endmodule

// File: rtl/dice_roll_collector.sv
// Buffers die rolls in a FIFO and keeps saturating per-face counts, a total and a sticky error flag.
module dice_roll_collector
    import dice_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic [2:0]       in_roll,
    output logic             in_ready,
    output logic             out_valid,
    output logic [2:0]       out_roll,
    input  logic             out_ready,
    input  logic             clr,
    input  logic [2:0]       face_sel,
    output logic [CNT_W-1:0] face_cnt,
    output logic [15:0]      total,
    output logic             err
);

    logic             roll_legal, accept;
    logic [CNT_W-1:0] cnt_q [NUM_FACES];
    logic [CNT_W-1:0] cnt_d [NUM_FACES];
    logic [15:0]      total_q, total_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] face_cnt_q, face_cnt_d;

    assign roll_legal = is_legal(in_roll);
    assign accept     = in_valid && in_ready;

    // Illegal rolls still consume a slot of the handshake but never reach the FIFO.
    roll_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid && roll_legal),
        .in_data   (in_roll),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_roll),
        .out_ready (out_ready)
    );

    always_comb begin
        cnt_d      = cnt_q;
        total_d    = total_q;
        err_d      = err_q;
        face_cnt_d = '0;
        if (clr) begin
            for (int i = 0; i < NUM_FACES; i++) cnt_d[i] = '0;
            total_d = '0;
            err_d   = 1'b0;
        end else begin
            if (accept && roll_legal) begin
                for (int i = 0; i < NUM_FACES; i++) begin
                    if (in_roll == face_t'(i + 1) && cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
                if (total_q != '1) total_d = total_q + 16'd1;
            end else if (accept) begin
                err_d = 1'b1;
            end
            for (int i = 0; i < NUM_FACES; i++) begin
                if (face_sel == face_t'(i + 1)) face_cnt_d = cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_FACES; i++) cnt_q[i] <= '0;
            total_q    <= '0;
            err_q      <= 1'b0;
            face_cnt_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            total_q    <= total_d;
            err_q      <= err_d;
            face_cnt_q <= face_cnt_d;
        end
    end

    assign face_cnt = face_cnt_q;
    assign total    = total_q;
    assign err      = err_q;

endmodule
